// File: rtl/ascon_pkg.sv
// ============================================================================
// Module      : ascon_pkg
// Description : Shared ASCON-128a types, constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

    localparam int          STATE_W  = 320;
    localparam int          RATE_W   = 128;
    localparam logic [7:0]  PAD_BYTE = 8'h80;

    localparam logic [7:0]  P8_RC [8] = '{8'hb4, 8'ha5, 8'h96, 8'h87,
                                          8'h78, 8'h69, 8'h5a, 8'h4b};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_EMIT   = 3'd2,
        ST_PERM   = 3'd3,
        ST_PAD    = 3'd4,
        ST_DONE   = 3'd5
    } fsm_e;

    // Ones over the leading n bytes (byte 0 is the MSB); n >= 16 gives all ones.
    function automatic logic [RATE_W-1:0] byte_mask(input logic [4:0] n);
        logic [RATE_W-1:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < n) m[RATE_W-1-8*i -: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_round.sv
// ============================================================================
// Module      : ascon_round
// Description : One combinational ASCON round: constant add, S-box, diffusion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [7:0]         i_rc,
    output logic [STATE_W-1:0] o_state
);

    function automatic logic [63:0] ror64(input logic [63:0] v, input int r);
        return (v >> r) | (v << (64 - r));
    endfunction

    logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

    // Bit-sliced S-box over the five 64-bit lanes.
    always_comb begin
        w_x0 = i_state[319:256];
        w_x1 = i_state[255:192];
        w_x2 = i_state[191:128] ^ {56'd0, i_rc};
        w_x3 = i_state[127:64];
        w_x4 = i_state[63:0];

        w_x0 = w_x0 ^ w_x4;
        w_x4 = w_x4 ^ w_x3;
        w_x2 = w_x2 ^ w_x1;
        w_t0 = ~w_x0 & w_x1;
        w_t1 = ~w_x1 & w_x2;
        w_t2 = ~w_x2 & w_x3;
        w_t3 = ~w_x3 & w_x4;
        w_t4 = ~w_x4 & w_x0;
        w_x0 = w_x0 ^ w_t1;
        w_x1 = w_x1 ^ w_t2;
        w_x2 = w_x2 ^ w_t3;
        w_x3 = w_x3 ^ w_t4;
        w_x4 = w_x4 ^ w_t0;
        w_x1 = w_x1 ^ w_x0;
        w_x0 = w_x0 ^ w_x4;
        w_x3 = w_x3 ^ w_x2;
        w_x2 = ~w_x2;
    end

    assign o_state = {w_x0 ^ ror64(w_x0, 19) ^ ror64(w_x0, 28),
                      w_x1 ^ ror64(w_x1, 61) ^ ror64(w_x1, 39),
                      w_x2 ^ ror64(w_x2,  1) ^ ror64(w_x2,  6),
                      w_x3 ^ ror64(w_x3, 10) ^ ror64(w_x3, 17),
                      w_x4 ^ ror64(w_x4,  7) ^ ror64(w_x4, 41)};

endmodule

`default_nettype wire

// File: rtl/pt_enc_absorb.sv
// ============================================================================
// Module      : pt_enc_absorb
// Description : ASCON-128a encrypt-side plaintext absorb / ciphertext emit.
//               ASCON_CT_TAIL_ZERO_EN zeroes ciphertext bytes beyond ct_bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pt_enc_absorb
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [STATE_W-1:0]  s_in,
    input  logic                pt_valid,
    output logic                pt_ready,
    input  logic [RATE_W-1:0]   pt_data,
    input  logic [4:0]          pt_bytes,
    input  logic                pt_last,
    output logic                ct_valid,
    input  logic                ct_ready,
    output logic [RATE_W-1:0]   ct_data,
    output logic [4:0]          ct_bytes,
    output logic [STATE_W-1:0]  s_out,
    output logic                done,
    output logic                busy
);

    localparam int         CAP_W      = STATE_W - RATE_W;
    localparam logic [2:0] c_rnd_step = 3'(UNROLL);
    localparam logic [2:0] c_rnd_last = 3'(8 - UNROLL);

    fsm_e                fsm_q, fsm_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [RATE_W-1:0]   ct_data_q, ct_data_d;
    logic [4:0]          ct_bytes_q, ct_bytes_d;
    logic                last_q, last_d;
    logic [2:0]          rnd_q, rnd_d;
    logic [STATE_W-1:0]  s_out_q, s_out_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                pt_ready_q, pt_ready_d;
    logic                ct_valid_q, ct_valid_d;

    logic [4:0]          w_n;
    logic [RATE_W-1:0]   w_rate, w_mask, w_xor, w_pad, w_rate_new, w_ct;
    logic [STATE_W-1:0]  w_state_abs, w_state_pad;
    logic [STATE_W-1:0]  w_chain [UNROLL+1];

    // Non-final beats are always full blocks; oversize byte counts saturate.
    assign w_n        = !pt_last ? 5'd16 : ((pt_bytes > 5'd16) ? 5'd16 : pt_bytes);
    assign w_rate     = state_q[STATE_W-1 -: RATE_W];
    assign w_mask     = byte_mask(w_n);
    assign w_xor      = pt_data ^ w_rate;
    assign w_pad      = (pt_last && (w_n < 5'd16))
                      ? (byte_mask(w_n + 5'd1) & ~w_mask & {16{PAD_BYTE}})
                      : '0;
    assign w_rate_new = ((w_rate & ~w_mask) | (w_xor & w_mask)) ^ w_pad;
    assign w_state_abs = {w_rate_new, state_q[CAP_W-1:0]};
    assign w_state_pad = state_q ^ {PAD_BYTE, {(STATE_W-8){1'b0}}};

`ifdef ASCON_CT_TAIL_ZERO_EN
    assign w_ct = w_xor & w_mask;
`else
    assign w_ct = w_xor;
`endif

    assign w_chain[0] = state_q;

    generate
        for (genvar k = 0; k < UNROLL; k++) begin : g_round
            ascon_round u_round (
                .i_state (w_chain[k]),
                .i_rc    (P8_RC[rnd_q + 3'(k)]),
                .o_state (w_chain[k+1])
            );
        end
    endgenerate

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        ct_data_d  = ct_data_q;
        ct_bytes_d = ct_bytes_q;
        last_d     = last_q;
        rnd_d      = rnd_q;
        s_out_d    = s_out_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        pt_ready_d = pt_ready_q;
        ct_valid_d = ct_valid_q;

        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = s_in;
                    busy_d     = 1'b1;
                    pt_ready_d = 1'b1;
                    fsm_d      = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                if (pt_valid) begin
                    state_d    = w_state_abs;
                    ct_data_d  = w_ct;
                    ct_bytes_d = w_n;
                    last_d     = pt_last;
                    pt_ready_d = 1'b0;
                    if (w_n == 5'd0) begin
                        s_out_d = w_state_abs;
                        done_d  = 1'b1;
                        fsm_d   = ST_DONE;
                    end else begin
                        ct_valid_d = 1'b1;
                        fsm_d      = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (ct_ready) begin
                    ct_valid_d = 1'b0;
                    if (!last_q || (ct_bytes_q == 5'd16)) begin
                        rnd_d = 3'd0;
                        fsm_d = ST_PERM;
                    end else begin
                        s_out_d = state_q;
                        done_d  = 1'b1;
                        fsm_d   = ST_DONE;
                    end
                end
            end
            ST_PERM: begin
                state_d = w_chain[UNROLL];
                rnd_d   = rnd_q + c_rnd_step;
                if (rnd_q == c_rnd_last) begin
                    // A full final block still owes its padding after the permutation.
                    if (last_q) begin
                        fsm_d = ST_PAD;
                    end else begin
                        pt_ready_d = 1'b1;
                        fsm_d      = ST_ABSORB;
                    end
                end
            end
            ST_PAD: begin
                state_d = w_state_pad;
                s_out_d = w_state_pad;
                done_d  = 1'b1;
                fsm_d   = ST_DONE;
            end
            ST_DONE: begin
                busy_d = 1'b0;
                fsm_d  = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            ct_data_q  <= '0;
            ct_bytes_q <= '0;
            last_q     <= 1'b0;
            rnd_q      <= '0;
            s_out_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            pt_ready_q <= 1'b0;
            ct_valid_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            ct_data_q  <= ct_data_d;
            ct_bytes_q <= ct_bytes_d;
            last_q     <= last_d;
            rnd_q      <= rnd_d;
            s_out_q    <= s_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            pt_ready_q <= pt_ready_d;
            ct_valid_q <= ct_valid_d;
        end
    end

    assign pt_ready = pt_ready_q;
    assign ct_valid = ct_valid_q;
    assign ct_data  = ct_data_q;
    assign ct_bytes = ct_bytes_q;
    assign s_out    = s_out_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pt_enc_absorb.sv
// ============================================================================
// Module      : tb_pt_enc_absorb
// Description : Directed self-checking bench for pt_enc_absorb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pt_enc_absorb;

    localparam int UNROLL = 1;
    localparam int PCYC   = 8 / UNROLL;
`ifdef ASCON_CT_TAIL_ZERO_EN
    localparam bit TZ = 1'b1;
`else
    localparam bit TZ = 1'b0;
`endif

    localparam logic [191:0] CAP = 192'hdeadbeefcafebabe_0f1e2d3c4b5a6978_1122334455667788;
    localparam logic [4:0]   SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                           5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                           5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                           5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0]   RC [8] = '{8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [319:0] s_in = '0;
    logic         pt_valid = 1'b0;
    logic         pt_ready;
    logic [127:0] pt_data = '0;
    logic [4:0]   pt_bytes = '0;
    logic         pt_last = 1'b0;
    logic         ct_valid;
    logic         ct_ready = 1'b0;
    logic [127:0] ct_data;
    logic [4:0]   ct_bytes;
    logic [319:0] s_out;
    logic         done;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    pt_enc_absorb #(.UNROLL(UNROLL)) dut (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .pt_bytes(pt_bytes), .pt_last(pt_last), .ct_valid(ct_valid),
        .ct_ready(ct_ready), .ct_data(ct_data), .ct_bytes(ct_bytes),
        .s_out(s_out), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ror(input logic [63:0] v, input int r);
        return (v >> r) | (v << (64 - r));
    endfunction

    function automatic logic [319:0] m_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
        x[2] = x[2] ^ {56'd0, c};
        for (int b = 0; b < 64; b++) begin
            v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
            for (int w = 0; w < 5; w++) y[w][b] = v[4-w];
        end
        return {y[0] ^ ror(y[0], 19) ^ ror(y[0], 28),
                y[1] ^ ror(y[1], 61) ^ ror(y[1], 39),
                y[2] ^ ror(y[2],  1) ^ ror(y[2],  6),
                y[3] ^ ror(y[3], 10) ^ ror(y[3], 17),
                y[4] ^ ror(y[4],  7) ^ ror(y[4], 41)};
    endfunction

    function automatic logic [319:0] m_p8(input logic [319:0] s);
        logic [319:0] t;
        t = s;
        for (int r = 0; r < 8; r++) t = m_round(t, RC[r]);
        return t;
    endfunction

    task automatic m_absorb(inout logic [319:0] s, input logic [127:0] pt, input logic [4:0] bytes,
                            input logic last, output logic [127:0] ct, output logic [4:0] n);
        logic [7:0] c;
        n = !last ? 5'd16 : ((bytes > 5'd16) ? 5'd16 : bytes);
        for (int i = 0; i < 16; i++) begin
            c = s[319-8*i -: 8] ^ pt[127-8*i -: 8];
            if (i < int'(n)) begin
                s[319-8*i -: 8] = c;
                ct[127-8*i -: 8] = c;
            end else begin
                ct[127-8*i -: 8] = TZ ? 8'h00 : c;
            end
        end
        if (last && n < 5'd16) s[319-8*int'(n) -: 8] = s[319-8*int'(n) -: 8] ^ 8'h80;
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_start(input logic [319:0] st);
        start = 1'b1;
        s_in  = st;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [4:0] b, input logic l);
        int cnt;
        pt_valid = 1'b1; pt_data = d; pt_bytes = b; pt_last = l;
        cnt = 0;
        while (!pt_ready && cnt < 100) begin @(negedge clk); cnt++; end
        if (cnt >= 100) begin n_tests++; n_fail++; $display("FAIL pt_ready_timeout: got 0 want 1"); end
        @(negedge clk);
        pt_valid = 1'b0; pt_last = 1'b0;
    endtask

    task automatic take_ct(input int stall);
        logic [127:0] held;
        int cnt;
        cnt = 0;
        while (!ct_valid && cnt < 100) begin @(negedge clk); cnt++; end
        if (cnt >= 100) begin n_tests++; n_fail++; $display("FAIL ct_valid_timeout: got 0 want 1"); end
        held = ct_data;
        for (int i = 0; i < stall; i++) begin
            start = (i == 0);
            s_in  = ~s_in;
            @(negedge clk);
            start = 1'b0;
            check("stall_ct_data", ct_data, held);
            check("stall_pt_ready", pt_ready, 1'b0);
        end
        ct_ready = 1'b1;
        @(negedge clk);
        ct_ready = 1'b0;
    endtask

    task automatic run_full(input logic [127:0] rate, input logic [127:0] pt, input logic [4:0] b);
        logic [319:0] st;
        logic [127:0] ct;
        logic [4:0]   n;
        int cnt;
        st = {rate, CAP};
        m_absorb(st, pt, b, 1'b1, ct, n);
        st = m_p8(st);
        st[319:312] = st[319:312] ^ 8'h80;
        do_start({rate, CAP});
        send_beat(pt, b, 1'b1);
        check("full_ct_data", ct_data, ct);
        check("full_ct_bytes", ct_bytes, 5'd16);
        take_ct(0);
        cnt = 0;
        while (!done && cnt < 100) begin @(negedge clk); cnt++; end
        check("full_done_latency", cnt, PCYC + 1);
        check("full_s_out", s_out, st);
        @(negedge clk);
        check("full_busy_drop", busy, 1'b0);
    endtask

    task automatic run_msg(input bit stall, input bit abort);
        logic [127:0] pts [3];
        logic [4:0]   bts [3];
        logic [319:0] st;
        logic [127:0] ct;
        logic [4:0]   n;
        int cnt;
        pts[0] = 128'h00112233445566778899aabbccddeeff;
        pts[1] = 128'hfedcba98765432100123456789abcdef;
        pts[2] = 128'h48656c6c6fa5a5a5a5a5a5a5a5a5a5a5;
        bts[0] = 5'd16; bts[1] = 5'd16; bts[2] = 5'd5;
        st = {128'h80800c0800000000_0123456789abcdef, CAP};
        do_start(st);
        for (int i = 0; i < 3; i++) begin
            m_absorb(st, pts[i], bts[i], i == 2, ct, n);
            send_beat(pts[i], bts[i], i == 2);
            check("msg_ct_data", ct_data, ct);
            check("msg_ct_bytes", ct_bytes, n);
            take_ct((stall && i == 1) ? 5 : 0);
            if (abort) begin
                rst = 1'b0;
                #1;
                check("abort_outputs", {pt_ready, ct_valid, ct_data, ct_bytes, done, busy}, '0);
                check("abort_s_out", s_out, '0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            if (i < 2) begin
                st = m_p8(st);
                cnt = 0;
                while (!pt_ready && cnt < 100) begin @(negedge clk); cnt++; end
                check("msg_ready_latency", cnt, PCYC);
            end
        end
        check("msg_done", done, 1'b1);
        check("msg_s_out", s_out, st);
        @(negedge clk);
        check("msg_busy_drop", busy, 1'b0);
    endtask

    // ---------------- single-beat vector table ----------------
    typedef struct {
        logic [127:0] rate;
        logic [127:0] pt;
        logic [4:0]   bytes;
        logic [127:0] ct_full;
        logic [127:0] ct_tz;
        logic [4:0]   exp_bytes;
        logic [127:0] exp_rate;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h11223300000000000000000000000000, 5'd3,
                    128'hEEDDCCFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'hEEDDCC00000000000000000000000000, 5'd3,
                    128'hEEDDCC7FFFFFFFFFFFFFFFFFFFFFFFFF};
        vecs[1] = '{128'h0123456789ABCDEF0123456789ABCDEF, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 5'd0,
                    128'h0, 128'h0, 5'd0,
                    128'h8123456789ABCDEF0123456789ABCDEF};
        vecs[2] = '{128'h0123456789ABCDEF0011223344556677, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 5'd8,
                    128'hFEDCBA9876543210FFEEDDCCBBAA9988, 128'hFEDCBA98765432100000000000000000, 5'd8,
                    128'hFEDCBA98765432108011223344556677};
        vecs[3] = '{128'h0, 128'h0102030405060708090A0B0C0D0E0F10, 5'd15,
                    128'h0102030405060708090A0B0C0D0E0F10, 128'h0102030405060708090A0B0C0D0E0F00, 5'd15,
                    128'h0102030405060708090A0B0C0D0E0F80};
        vecs[4] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h5A000000000000000000000000000000, 5'd1,
                    128'hA5FFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'hA5000000000000000000000000000000, 5'd1,
                    128'hA57FFFFFFFFFFFFFFFFFFFFFFFFFFFFF};

        @(negedge clk);
        check("reset_outputs", {pt_ready, ct_valid, ct_data, ct_bytes, done, busy}, '0);
        check("reset_s_out", s_out, '0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            do_start({vecs[v].rate, CAP});
            check("vec_busy", busy, 1'b1);
            send_beat(vecs[v].pt, vecs[v].bytes, 1'b1);
            if (vecs[v].exp_bytes == 5'd0) begin
                check("nobeat_ct_valid", ct_valid, 1'b0);
            end else begin
                check("vec_ct_valid", ct_valid, 1'b1);
                check("vec_ct_data", ct_data, TZ ? vecs[v].ct_tz : vecs[v].ct_full);
                check("vec_ct_bytes", ct_bytes, vecs[v].exp_bytes);
                ct_ready = 1'b1;
                @(negedge clk);
                ct_ready = 1'b0;
            end
            check("vec_done", done, 1'b1);
            check("vec_s_out", s_out, {vecs[v].exp_rate, CAP});
            @(negedge clk);
            check("vec_done_pulse", done, 1'b0);
            check("vec_busy_drop", busy, 1'b0);
        end

        run_full(128'h0, 128'h000102030405060708090A0B0C0D0E0F, 5'd16);
        run_full(128'h0123456789ABCDEF0123456789ABCDEF, 128'h5555AAAA5555AAAA0F0F0F0FF0F0F0F0, 5'd20);
        run_msg(1'b1, 1'b0);
        run_msg(1'b0, 1'b1);
        run_msg(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pt_enc_absorb.md
Name: pt_enc_absorb

Overview:
- Encryption-side plaintext processing stage for the ASCON-128a core; mirror of the ciphertext/decrypt stage.
- Takes the 320-bit state after associated-data processing and streams 128-bit plaintext beats in.
- Emits ciphertext beats and runs an iterative p8 between full blocks.
- Applies final padding and hands the pre-finalization state to the tag stage.

Parameters:
- UNROLL, 1, ASCON rounds computed per clock. Legal values: 1, 2, 4, 8. One p8 takes 8/UNROLL cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches s_in, begins message
- s_in  in  320  state after AD phase; rate is s[319:192]
- pt_valid  in  1  plaintext beat valid
- pt_ready  out  1  block accepts a beat
- pt_data  in  128  plaintext; byte 0 at [127:120], maps onto s[319:312]
- pt_bytes  in  5  valid bytes, 0..16; honoured only when pt_last=1
- pt_last  in  1  final beat of the message
- ct_valid  out  1  ciphertext beat valid
- ct_ready  in  1  downstream accepts the beat
- ct_data  out  128  ciphertext, same byte order as pt_data
- ct_bytes  out  5  valid ciphertext bytes
- s_out  out  320  padded state for finalization; valid when done=1, held until next start
- done  out  1  one-cycle pulse when s_out is valid
- busy  out  1  high from start until done

Behaviour:
- Reset: FSM=IDLE. All outputs 0: pt_ready, ct_valid, ct_data, ct_bytes, s_out, done, busy. Internal state register cleared.
- FSM states: IDLE, ABSORB, EMIT, PERM, PAD, DONE.
- IDLE:
  - On start, state <= s_in, busy=1, go to ABSORB.
  - start is ignored outside IDLE.
- ABSORB (pt_ready=1). On pt_valid & pt_ready:
  - n = 16 if pt_last=0, else pt_bytes.
  - ct byte i = pt byte i ^ rate byte i, for i<n.
  - Rate bytes i<n are replaced by the ct bytes.
  - If pt_last=1 and n<16: rate byte n ^= 0x80.
  - Register ct_data and ct_bytes=n.
  - If n=0 (pt_last=1, pt_bytes=0): no ct beat is produced; the pad is applied and the FSM goes directly to DONE.
  - Otherwise go to EMIT.
  - pt_bytes>16 is treated as 16.
- EMIT (ct_valid=1; ct_data/ct_bytes stable until handshake). On ct_ready:
  - not last → PERM
  - last with n<16 → DONE
  - last with n=16 → PERM, then PAD
- PERM:
  - Runs p8 with round constants b4,a5,96,87,78,69,5a,4b, UNROLL rounds per cycle.
  - Exits after 8/UNROLL cycles to ABSORB, or to PAD if the last block was full.
- PAD (1 cycle): s[319:312] ^= 0x80, then DONE.
- DONE (1 cycle): s_out <= state, done=1, busy drops next cycle, return to IDLE.
- Latency, full non-last block, no backpressure: beat accepted at T, ct_valid at T+1, PERM for 8/UNROLL cycles, pt_ready again at T+2+8/UNROLL.
- No permutation after the final block; finalization is owned by the tag stage.
- Capacity bits s[191:0] are untouched except by PERM.
- rst low mid-operation: immediately returns to reset values. A partial message is discarded and no done is issued.

Optional Feature:
- ASCON_CT_TAIL_ZERO_EN.
- Defined: ct_data bytes at index ≥ ct_bytes are forced to 0, so no keystream leaks on partial blocks.
- Undefined: those bytes carry pt^rate, which saves area.
- ct_bytes, state update and s_out are identical either way.

Decomposition:
- Shared package ascon_pkg holds:
  - STATE_W=320, RATE_W=128, PAD_BYTE=8'h80
  - P8 round-constant array
  - FSM state enum
  - Byte-mask helper function (n → 128-bit mask)
- One sub-module, ascon_round: one ASCON round (constant addition, 5-bit S-box layer, linear diffusion). Instantiated UNROLL times in a chain inside the PERM datapath.

Test Plan:
- s_in rate=0, capacity=0; one beat, pt_last=1, pt_bytes=16, pt_data=128'h000102..0F
  → ct_data=000102..0F, ct_bytes=16; PERM occurs, then PAD.
  → s_out equals golden p8(state) with s[319:312]^0x80.
- s_in rate=128'hFF..FF; pt_last=1, pt_bytes=3, pt_data=128'h112233_00..00
  → ct top bytes EEDDCC, ct_bytes=3.
  → s_out[319:192]=128'hEEDDCC7F_FF..FF, s_out[191:0]=s_in[191:0].
  → done 2 cycles after ct handshake start.
- start then pt_last=1, pt_bytes=0 → no ct_valid; s_out = s_in with bit 319 flipped; done one cycle after the beat.
- Three-beat message with ct_ready held low 5 cycles on beat 2
  → ct_data stable and pt_ready=0 throughout the stall.
  → outputs match golden ASCON-128a encryption for UNROLL=1 and UNROLL=4.
- rst asserted during PERM of beat 1 → all outputs 0 next edge; a new start with the same vectors gives the correct result.
- Partial block with ASCON_CT_TAIL_ZERO_EN defined → ct_data[103:0]=0; undefined → ct_data[103:0] = pt^rate.
